// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared states, default widths and timing helpers for adder_delay_sequencer
package adder_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    RUN     = 3'd3,
    STOP    = 3'd4,
    CAPTURE = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int DEF_WIDTH         = 32;
  localparam int DEF_CNT_W         = 32;
  localparam int DEF_RUNS_W        = 8;
  localparam int DEF_ACC_W         = 40;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_RUN_CYCLES    = 1024;
  localparam int DEF_SYNC_CYCLES   = 2;

  // Clocks spent per run: LOAD + SETTLE + RUN + STOP + CAPTURE.
  function automatic int cycles_per_run(input int settle, input int run, input int sync);
    return 1 + settle + run + sync + 1;
  endfunction

  function automatic int max3(input int x, input int y, input int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

endpackage

// File: rtl/adder_seq_timer.sv
// rtl/adder_seq_timer.sv - loadable down-counter with done flag shared by SETTLE, RUN and STOP
module adder_seq_timer #(
  parameter int W = 11
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Load a new interval, otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/adder_delay_sequencer.sv
// rtl/adder_delay_sequencer.sv - run sequencer for the ring-oscillator adder; optional sum check via ADDER_SEQ_SUM_CHECK_EN
module adder_delay_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int RUNS_W        = DEF_RUNS_W,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RUN_CYCLES    = DEF_RUN_CYCLES,
  parameter int SYNC_CYCLES   = DEF_SYNC_CYCLES
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIDTH-1:0]  req_a,
  input  logic [WIDTH-1:0]  req_b,
  input  logic [RUNS_W-1:0] req_runs,
  output logic [WIDTH-1:0]  adder_a,
  output logic [WIDTH-1:0]  adder_b,
  output logic              ring_en,
  output logic              ring_clear,
  input  logic [CNT_W-1:0]  ring_count_i,
  input  logic [WIDTH-1:0]  sum_i,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_count,
  output logic [RUNS_W-1:0] res_runs,
  output logic              res_err,
  output logic              busy
);

  localparam int TMR_W = $clog2(max3(SETTLE_CYCLES, RUN_CYCLES, SYNC_CYCLES) + 1);
  localparam logic [TMR_W-1:0] L_SETTLE = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] L_RUN    = TMR_W'(RUN_CYCLES - 1);
  localparam logic [TMR_W-1:0] L_SYNC   = TMR_W'(SYNC_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [RUNS_W-1:0]  r_runs;
  logic [RUNS_W-1:0]  r_run_idx;
  logic [ACC_W-1:0]   r_acc;
  logic [WIDTH-1:0]   r_adder_a;
  logic [WIDTH-1:0]   r_adder_b;
  logic               w_accept;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_tmr_done;
  logic [RUNS_W-1:0]  w_idx_next;
  logic [ACC_W:0]     w_acc_sum;
  logic [ACC_W-1:0]   w_acc_next;

  adder_seq_timer #(.W(TMR_W)) u_timer (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n),
    .i_load  (w_tmr_load),
    .i_val   (w_tmr_val),
    .o_done  (w_tmr_done)
  );

  assign w_idx_next = r_run_idx + RUNS_W'(1);
  // One extra bit catches the carry so the accumulator clamps instead of wrapping.
  assign w_acc_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - CNT_W){1'b0}}, ring_count_i};
  assign w_acc_next = w_acc_sum[ACC_W] ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Next-state, timer control and handshake/ring outputs.
  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    ring_en    = 1'b0;
    ring_clear = 1'b0;
    res_valid  = 1'b0;
    req_ready  = 1'b0;
    busy       = (r_state != IDLE);
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        // Gated by reset so every output reads 0 while reset is held.
        req_ready = wb_rst_n;
        w_accept  = req_valid && wb_rst_n;
        if (w_accept) w_next = LOAD;
      end
      LOAD: begin
        ring_clear = 1'b1;
        w_tmr_load = 1'b1;
        w_tmr_val  = L_SETTLE;
        w_next     = SETTLE;
      end
      SETTLE: begin
        if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = L_RUN;
          w_next     = RUN;
        end
      end
      RUN: begin
        ring_en = 1'b1;
        if (w_tmr_done) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = L_SYNC;
          w_next     = STOP;
        end
      end
      STOP: begin
        if (w_tmr_done) w_next = CAPTURE;
      end
      CAPTURE: begin
        w_next = (w_idx_next == r_runs) ? DONE : LOAD;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request latches, operand drive, run index and accumulator.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_runs    <= '0;
      r_run_idx <= '0;
      r_acc     <= '0;
      r_adder_a <= '0;
      r_adder_b <= '0;
    end else begin
      if (w_accept) begin
        r_a       <= req_a;
        r_b       <= req_b;
        r_runs    <= (req_runs == '0) ? RUNS_W'(1) : req_runs;
        r_run_idx <= '0;
        r_acc     <= '0;
      end
      if (r_state == LOAD) begin
        r_adder_a <= r_a;
        r_adder_b <= r_b;
      end
      if (r_state == CAPTURE) begin
        r_acc     <= w_acc_next;
        r_run_idx <= w_idx_next;
      end
    end
  end

  assign adder_a   = r_adder_a;
  assign adder_b   = r_adder_b;
  assign res_count = r_acc;
  assign res_runs  = r_runs;

`ifdef ADDER_SEQ_SUM_CHECK_EN
  logic             r_err;
  logic [WIDTH-1:0] w_exp_sum;

  assign w_exp_sum = r_a + r_b;

  // Sticky sum-mismatch flag, cleared when a new request is taken.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (r_state == CAPTURE && sum_i != w_exp_sum) begin
      r_err <= 1'b1;
    end
  end

  assign res_err = r_err;
`else
  logic w_unused_sum;

  assign w_unused_sum = ^sum_i;
  assign res_err      = 1'b0;
`endif

endmodule

// File: tb/tb_adder_delay_sequencer.sv
// tb/tb_adder_delay_sequencer.sv - directed vector bench for adder_delay_sequencer
module tb_adder_delay_sequencer;
  import adder_seq_pkg::*;

  localparam int LAT1 = cycles_per_run(4, 1024, 2);

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_runs;
  logic [31:0] adder_a;
  logic [31:0] adder_b;
  logic        ring_en;
  logic        ring_clear;
  logic [31:0] ring_count_i;
  logic [31:0] sum_i;
  logic        res_valid;
  logic        res_ready;
  logic [39:0] res_count;
  logic [7:0]  res_runs;
  logic        res_err;
  logic        busy;

  int n_tests;
  int n_fail;

  adder_delay_sequencer dut (
    .wb_clk_i     (clk),
    .wb_rst_n     (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_runs     (req_runs),
    .adder_a      (adder_a),
    .adder_b      (adder_b),
    .ring_en      (ring_en),
    .ring_clear   (ring_clear),
    .ring_count_i (ring_count_i),
    .sum_i        (sum_i),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_count    (res_count),
    .res_runs     (res_runs),
    .res_err      (res_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: sum follows the driven operands, optionally corrupted.
  logic [31:0] sum_flip;
  assign sum_i = (adder_a + adder_b) ^ sum_flip;

  // Ring counter model: cleared by ring_clear, presents the scripted count once a window closes.
  logic [31:0] model_cnt [4];
  int          win_idx;
  int          n_clr;
  int          n_en;
  logic        prev_en;

  always @(negedge clk) begin
    if (ring_clear) begin
      ring_count_i = 32'd0;
      n_clr++;
    end
    if (ring_en) n_en++;
    if (prev_en && !ring_en) begin
      ring_count_i = (win_idx < 4) ? model_cnt[win_idx] : 32'd0;
      win_idx++;
    end
    prev_en = ring_en;
  end

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [7:0]       runs;
    logic [3:0][31:0] cnt;
    logic [39:0]      exp_count;
    logic [7:0]       exp_runs;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and wait for res_valid; lat is edges from acceptance to res_valid.
  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [7:0] runs,
                         input logic [3:0][31:0] cnt, output int lat);
    @(negedge clk);
    for (int i = 0; i < 4; i++) model_cnt[i] = cnt[i];
    win_idx   = 0;
    req_a     = a;
    req_b     = b;
    req_runs  = runs;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_clr     = 0;
    n_en      = 0;
    lat       = 0;
    @(negedge clk);
    while (!res_valid && lat < 20000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check("idle_busy", {63'd0, busy}, 64'd0);
    check("idle_req_ready", {63'd0, req_ready}, 64'd1);
  endtask

  int          lat;
  int          nr;
  logic [39:0] held_cnt;
  logic        stable;
  logic        saw_valid;

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_a = '0; req_b = '0; req_runs = '0;
    ring_count_i = '0; sum_flip = '0;
    win_idx = 0; n_clr = 0; n_en = 0; prev_en = 1'b0;

    vecs[0] = '{a: 32'd3, b: 32'd5, runs: 8'd1, cnt: {32'd0, 32'd0, 32'd0, 32'd100},
                exp_count: 40'd100, exp_runs: 8'd1};
    vecs[1] = '{a: 32'h1234, b: 32'h0F0F, runs: 8'd4, cnt: {32'd40, 32'd30, 32'd20, 32'd10},
                exp_count: 40'd100, exp_runs: 8'd4};
    vecs[2] = '{a: 32'hA5A5A5A5, b: 32'h5A5A5A5A, runs: 8'd0, cnt: {32'd0, 32'd0, 32'd0, 32'd77},
                exp_count: 40'd77, exp_runs: 8'd1};
    vecs[3] = '{a: 32'hDEADBEEF, b: 32'h1, runs: 8'd2,
                cnt: {32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF},
                exp_count: 40'h01FFFFFFFE, exp_runs: 8'd2};

    // Reset held for 3 cycles: every output reads 0.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ring", {62'd0, ring_en, ring_clear}, 64'd0);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_res", {16'd0, res_count, res_runs}, 64'd0);
    check("rst_adder", {adder_a, adder_b}, 64'd0);
    check("rst_res_err", {63'd0, res_err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

    for (int v = 0; v < 4; v++) begin
      nr = (vecs[v].runs == 8'd0) ? 1 : int'(vecs[v].runs);
      run_req(vecs[v].a, vecs[v].b, vecs[v].runs, vecs[v].cnt, lat);
      check($sformatf("v%0d_latency", v), 64'(lat), 64'(nr * LAT1));
      check($sformatf("v%0d_res_count", v), 64'(res_count), 64'(vecs[v].exp_count));
      check($sformatf("v%0d_res_runs", v), 64'(res_runs), 64'(vecs[v].exp_runs));
      check($sformatf("v%0d_ring_clear_pulses", v), 64'(n_clr), 64'(nr));
      check($sformatf("v%0d_ring_en_cycles", v), 64'(n_en), 64'(nr * 1024));
      check($sformatf("v%0d_req_ready_busy", v), {62'd0, req_ready, busy}, 64'd1);
      check($sformatf("v%0d_res_err", v), {63'd0, res_err}, 64'd0);
      if (v == 1) begin
        // Backpressure: hold res_ready low 50 cycles while pushing a stray request.
        held_cnt = res_count;
        stable   = 1'b1;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk);
          req_valid = 1'b1;
          req_a     = $urandom;
          req_runs  = 8'd3;
          if (!res_valid || res_count != held_cnt || req_ready || res_runs != 8'd4) stable = 1'b0;
        end
        check("bp_outputs_stable", {63'd0, stable}, 64'd1);
      end
      handshake();
      check($sformatf("v%0d_operands_held", v), {adder_a, adder_b}, {vecs[v].a, vecs[v].b});
    end

    // Reset in the middle of RUN drops ring_en and discards the run.
    @(negedge clk);
    for (int i = 0; i < 4; i++) model_cnt[i] = 32'd999;
    win_idx = 0; req_a = 32'd9; req_b = 32'd9; req_runs = 8'd3; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 0; c < 200 && !ring_en; c++) @(negedge clk);
    repeat (100) @(negedge clk);
    check("mid_run_ring_en_before", {63'd0, ring_en}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ring_en", {63'd0, ring_en}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_res_count", 64'(res_count), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (res_valid || busy) saw_valid = 1'b1;
    end
    check("mid_rst_no_result", {63'd0, saw_valid}, 64'd0);
    run_req(32'd7, 32'd8, 8'd1, {32'd0, 32'd0, 32'd0, 32'd55}, lat);
    check("restart_latency", 64'(lat), 64'(LAT1));
    check("restart_res_count", 64'(res_count), 64'd55);
    check("restart_res_runs", 64'(res_runs), 64'd1);
    handshake();

`ifdef ADDER_SEQ_SUM_CHECK_EN
    run_req(32'hFFFFFFFF, 32'd1, 8'd1, {32'd0, 32'd0, 32'd0, 32'd5}, lat);
    check("sum_ok_sum_i", 64'(sum_i), 64'd0);
    check("sum_ok_res_err", {63'd0, res_err}, 64'd0);
    handshake();
    sum_flip = 32'd1;
    run_req(32'hFFFFFFFF, 32'd1, 8'd1, {32'd0, 32'd0, 32'd0, 32'd5}, lat);
    check("sum_bad_res_err", {63'd0, res_err}, 64'd1);
    handshake();
    check("sum_err_sticky_idle", {63'd0, res_err}, 64'd1);
    sum_flip = 32'd0;
    @(negedge clk);
    req_a = 32'd1; req_b = 32'd2; req_runs = 8'd1; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("sum_err_cleared_on_accept", {63'd0, res_err}, 64'd0);
    for (int c = 0; c < 2000 && !res_valid; c++) @(negedge clk);
    handshake();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
